img_pixel_streamer: RTL



---
 rtl/img_stream_pkg.sv | 22 ++
 rtl/pix_fifo2.sv | 76 +++++++
 rtl/img_pixel_streamer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/img_stream_pkg.sv
// Shared defaults, state encoding and pixel type for the image streaming datapath.
package img_stream_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IMG_W  = 256;
  localparam int DEF_IMG_H  = 256;
  localparam int DEF_ADDR_W = 16;

  typedef logic [DEF_DATA_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_e;

  // Raster step in both axes: 2 when decimating, 1 for the full image.
  function automatic int scan_step(input bit decimate);
    return decimate ? 2 : 1;
  endfunction

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry stream buffer carrying pixel data plus an end-of-frame tag.
// The head entry is a flop, so head_data/head_last/head_valid are registered.
module pix_fifo2
  import img_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic              head_valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic              last0_q, last0_d;
  logic              last1_q, last1_d;
  logic [1:0]        count_q, count_d;
  logic              pop_ok;
  logic              push_ok;
  logic [1:0]        occ_after_pop;

  assign pop_ok        = pop && (count_q != 2'd0);
  assign push_ok       = push && ((count_q != 2'd2) || pop_ok);
  assign occ_after_pop = count_q - {1'b0, pop_ok};

  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    count_d = occ_after_pop + {1'b0, push_ok};
    if (pop_ok) begin
      data0_d = data1_q;
      last0_d = last1_q;
    end
    // A push lands in the first slot still free after this cycle's pop.
    if (push_ok) begin
      if (occ_after_pop == 2'd0) begin
        data0_d = push_data;
        last0_d = push_last;
      end else begin
        data1_d = push_data;
        last1_d = push_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      count_q <= count_d;
    end
  end

  assign head_data  = data0_q;
  assign head_last  = last0_q;
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/img_pixel_streamer.sv
// Raster-order frame reader: walks a synchronous-read frame memory and emits a
// valid/ready pixel stream. Define DOWNSAMPLE_2X_EN for 2:1 decimation in both axes.
module img_pixel_streamer
  import img_stream_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              frame_done
);

`ifdef DOWNSAMPLE_2X_EN
  localparam bit DECIMATE = 1'b1;
`else
  localparam bit DECIMATE = 1'b0;
`endif

  localparam int                STEP     = scan_step(DECIMATE);
  localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ROW_JUMP = ADDR_W'(STEP + (STEP - 1) * IMG_W);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - STEP);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - STEP);

  localparam logic [1:0] IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] RUN   = 2'(ST_RUN);
  localparam logic [1:0] DRAIN = 2'(ST_DRAIN);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              frame_done_q, frame_done_d;

  logic [DATA_W-1:0] head_data;
  logic              head_last;
  logic              head_valid;
  logic [1:0]        fifo_count;
  logic              pop;
  logic              last_read;
  logic              rd_en;
  logic [2:0]        occupancy;

  assign pop       = head_valid && pix_ready;
  assign last_read = (row_q == LAST_ROW) && (col_q == LAST_COL);

  // Slots spoken for after this cycle: buffered pixels plus the read landing now, minus the pop.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en     = (state_q == RUN) && (occupancy < 3'd2);

  always_comb begin
    state_d         = state_q;
    row_d           = row_q;
    col_d           = col_q;
    addr_d          = addr_q;
    frame_done_d    = 1'b0;
    inflight_d      = rd_en;
    inflight_last_d = rd_en && last_read;
    case (state_q)
      IDLE: begin
        if (start && !frame_done_q) begin
          state_d = RUN;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
        end
      end
      RUN: begin
        if (rd_en) begin
          if (last_read) begin
            state_d = DRAIN;
            row_d   = '0;
            col_d   = '0;
            addr_d  = '0;
          end else if (col_q == LAST_COL) begin
            col_d  = '0;
            row_d  = row_q + STEP_A;
            addr_d = addr_q + ROW_JUMP;
          end else begin
            col_d  = col_q + STEP_A;
            addr_d = addr_q + STEP_A;
          end
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      row_q           <= '0;
      col_q           <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      col_q           <= col_d;
      addr_q          <= addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      frame_done_q    <= frame_done_d;
    end
  end

  pix_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (mem_rdata),
    .push_last (inflight_last_q),
    .pop       (pop),
    .head_data (head_data),
    .head_last (head_last),
    .head_valid(head_valid),
    .count     (fifo_count)
  );

  assign busy       = (state_q != IDLE);
  assign mem_rd_en  = rd_en;
  assign mem_addr   = addr_q;
  assign pix_out    = head_data;
  assign pix_valid  = head_valid;
  assign pix_last   = head_valid && head_last;
  assign frame_done = frame_done_q;

endmodule
